// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pisa_mem_pkg
// Description : Shared access-size and LSU state types for the memory path.
// Revision    : 1.0 - initial release
// ============================================================================
package pisa_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'b00,
        LSU_ACCESS  = 2'b01,
        LSU_CAPTURE = 2'b10,
        LSU_RESP    = 2'b11
    } lsu_state_t;

    function automatic logic [2:0] size_bytes(input mem_size_t size);
        case (size)
            MEM_BYTE: size_bytes = 3'd1;
            MEM_HALF: size_bytes = 3'd2;
            default:  size_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response handshake between execute stage and the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_tag,
        output resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_tag,
        input  resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_fault
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Sign/zero extension of right-aligned load data by access size.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import pisa_mem_pkg::*;
(
    input  logic [31:0] mem_out,
    input  mem_size_t   size,
    input  logic        is_signed,
    output logic [31:0] result
);
    always_comb begin
        result = mem_out;
        case (size)
            MEM_BYTE: result = {{24{is_signed & mem_out[7]}}, mem_out[7:0]};
            MEM_HALF: result = {{16{is_signed & mem_out[15]}}, mem_out[15:0]};
            default:  result = mem_out;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Sequences one bounds-checked load/store into the byte-lane BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import pisa_mem_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int TAG_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic [31:0]         mem_address,
    output logic [31:0]         mem_in,
    output logic [1:0]          mem_size,
    output logic                mem_write_enable,
    input  logic [31:0]         mem_out
);
    lsu_state_t       r_state;
    lsu_state_t       w_state_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_resp_data;
    logic [31:0]      w_load_data;
    mem_size_t        r_size;
    mem_size_t        w_req_size;
    logic             r_signed;
    logic             r_write;
    logic             r_fault;
    logic [TAG_W-1:0] r_tag;
    logic [32:0]      w_end_addr;
    logic             w_fault;
    logic             w_accept;

    // 2'b11 is a word access too; normalise so Memory only ever sees legal sizes.
    assign w_req_size = bus.req_size[1] ? MEM_WORD : mem_size_t'(bus.req_size);
    // 33-bit end address keeps accesses near 0xFFFFFFFF from wrapping into range.
    assign w_end_addr = {1'b0, bus.req_addr} + {30'd0, size_bytes(w_req_size)};
    assign w_fault    = w_end_addr > 33'(MEM_BYTES);
    assign w_accept   = (r_state == LSU_IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_IDLE:    if (bus.req_valid) w_state_next = w_fault ? LSU_RESP : LSU_ACCESS;
            LSU_ACCESS:  w_state_next = r_write ? LSU_RESP : LSU_CAPTURE;
            LSU_CAPTURE: w_state_next = LSU_RESP;
            LSU_RESP:    if (bus.resp_ready) w_state_next = LSU_IDLE;
            default:     w_state_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (r_state == LSU_IDLE);
        bus.resp_valid   = (r_state == LSU_RESP);
        mem_write_enable = (r_state == LSU_ACCESS) && r_write && !rst;
    end

    load_extend u_extend (
        .mem_out   (mem_out),
        .size      (r_size),
        .is_signed (r_signed),
        .result    (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= MEM_BYTE;
            r_signed    <= 1'b0;
            r_write     <= 1'b0;
            r_fault     <= 1'b0;
            r_tag       <= '0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_size      <= w_req_size;
            r_signed    <= bus.req_signed;
            r_write     <= bus.req_write;
            r_fault     <= w_fault;
            r_tag       <= bus.req_tag;
            r_resp_data <= '0;
        end else if (r_state == LSU_CAPTURE) begin
            r_resp_data <= w_load_data;
        end
    end

    assign mem_address    = r_addr;
    assign mem_in         = r_wdata;
    assign mem_size       = r_size;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_tag;
    assign bus.resp_fault = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed and randomized checks of load_store_unit against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    localparam int MEM_BYTES = 8192;
    localparam int TAG_W     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.TAG_W(TAG_W)) bus ();

    logic [31:0] mem_address;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic [1:0]  mem_size;
    logic        mem_write_enable;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .mem_address      (mem_address),
        .mem_in           (mem_in),
        .mem_size         (mem_size),
        .mem_write_enable (mem_write_enable),
        .mem_out          (mem_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-lane BRAM: little-endian lanes, one-cycle synchronous read.
    logic [7:0]  bram [0:MEM_BYTES-1];
    logic        preload = 1'b0;
    logic [12:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int          we_count = 0;

    always @(posedge clk) begin
        if (preload) begin
            bram[pl_addr] <= pl_data;
        end else if (mem_write_enable) begin
            bram[13'(mem_address)] <= mem_in[7:0];
            if (mem_size != 2'b00) bram[13'(mem_address + 32'd1)] <= mem_in[15:8];
            if (mem_size[1]) begin
                bram[13'(mem_address + 32'd2)] <= mem_in[23:16];
                bram[13'(mem_address + 32'd3)] <= mem_in[31:24];
            end
        end
        mem_out <= {bram[13'(mem_address + 32'd3)], bram[13'(mem_address + 32'd2)],
                    bram[13'(mem_address + 32'd1)], bram[13'(mem_address)]};
        if (mem_write_enable) we_count <= we_count + 1;
    end

    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic void model(input bit w, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] exp_data, output bit exp_fault,
                                  output int exp_lat);
        int     nb;
        longint val;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_data  = 32'h0;
        exp_fault = 1'b0;
        if (longint'({32'h0, a}) + longint'(nb) > longint'(MEM_BYTES)) begin
            exp_fault = 1'b1;
            exp_lat   = 1;
        end else if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            exp_lat = 2;
        end else begin
            val = 0;
            for (int i = 0; i < nb; i++) val = val + (longint'(ref_mem[int'(a) + i]) << (8 * i));
            if (sg && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
            exp_data = val[31:0];
            exp_lat  = 3;
        end
    endfunction

    task automatic send(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] tg,
                        output logic [31:0] d, output logic flt, output logic [4:0] rt,
                        output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_tag    = tg;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d   = bus.resp_data;
        flt = bus.resp_fault;
        rt  = bus.resp_tag;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    logic [31:0] d, ed;
    logic        f;
    bit          ef;
    logic [4:0]  t;
    int          lat, el;

    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, mem_write_enable} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 1000", {bus.req_ready, bus.resp_valid, bus.resp_fault, mem_write_enable});
        end
        n_tests++;
        if ({bus.resp_data, bus.resp_tag, mem_address, mem_in, mem_size} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h tag=%h addr=%h in=%h size=%b want all zero",
                     bus.resp_data, bus.resp_tag, mem_address, mem_in, mem_size);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int w0;
        w0 = we_count;
        model(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, ed, ef, el);
        send(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd3, d, f, t, lat);
        n_tests++;
        if (lat !== 2 || d !== 32'h0 || f !== 1'b0 || t !== 5'd3 || we_count !== w0 + 1) begin
            n_fail++;
            $display("FAIL store_word: lat=%0d data=%h fault=%b tag=%0d writes=%0d want 2/0/0/3/%0d",
                     lat, d, f, t, we_count - w0, 1);
        end
        model(0, 2'b10, 0, 32'h10, 32'h0, ed, ef, el);
        send(0, 2'b10, 0, 32'h10, 32'h0, 5'd17, d, f, t, lat);
        n_tests++;
        if (lat !== 3 || d !== 32'hDEADBEEF || f !== 1'b0 || t !== 5'd17) begin
            n_fail++;
            $display("FAIL load_word: lat=%0d data=%h fault=%b tag=%0d want 3/deadbeef/0/17", lat, d, f, t);
        end
    endtask

    task automatic test_sign_extend();
        model(1, 2'b00, 0, 32'h21, 32'h80, ed, ef, el);
        send(1, 2'b00, 0, 32'h21, 32'h80, 5'd1, d, f, t, lat);
        send(0, 2'b00, 1, 32'h21, 32'h0, 5'd2, d, f, t, lat);
        n_tests++;
        if (d !== 32'hFFFFFF80 || t !== 5'd2) begin
            n_fail++;
            $display("FAIL load_byte_signed: data=%h tag=%0d want ffffff80/2", d, t);
        end
        send(0, 2'b00, 0, 32'h21, 32'h0, 5'd4, d, f, t, lat);
        n_tests++;
        if (d !== 32'h00000080) begin
            n_fail++;
            $display("FAIL load_byte_unsigned: data=%h want 00000080", d);
        end
        send(0, 2'b10, 0, 32'h20, 32'h0, 5'd5, d, f, t, lat);
        n_tests++;
        if (d[15:8] !== 8'h80) begin
            n_fail++;
            $display("FAIL load_word_lane1: data[15:8]=%h want 80", d[15:8]);
        end
    endtask

    task automatic test_unaligned();
        model(1, 2'b10, 0, 32'h3, 32'h11223344, ed, ef, el);
        send(1, 2'b10, 0, 32'h3, 32'h11223344, 5'd6, d, f, t, lat);
        send(0, 2'b10, 0, 32'h3, 32'h0, 5'd7, d, f, t, lat);
        n_tests++;
        if (d !== 32'h11223344) begin
            n_fail++;
            $display("FAIL unaligned_word: data=%h want 11223344", d);
        end
        send(0, 2'b00, 0, 32'h3, 32'h0, 5'd8, d, f, t, lat);
        n_tests++;
        if (d !== 32'h00000044) begin
            n_fail++;
            $display("FAIL unaligned_byte: data=%h want 00000044", d);
        end
        send(0, 2'b01, 1, 32'h5, 32'h0, 5'd9, d, f, t, lat);
        n_tests++;
        if (d !== 32'h00001122) begin
            n_fail++;
            $display("FAIL unaligned_half_signed: data=%h want 00001122", d);
        end
    endtask

    task automatic test_fault();
        int w0;
        w0 = we_count;
        send(0, 2'b10, 0, 32'(MEM_BYTES - 3), 32'h0, 5'd10, d, f, t, lat);
        n_tests++;
        if (f !== 1'b1 || d !== 32'h0 || lat !== 1 || t !== 5'd10) begin
            n_fail++;
            $display("FAIL fault_word_end: fault=%b data=%h lat=%0d tag=%0d want 1/0/1/10", f, d, lat, t);
        end
        send(1, 2'b00, 0, 32'hFFFFFFFF, 32'h5A, 5'd11, d, f, t, lat);
        n_tests++;
        if (f !== 1'b1 || d !== 32'h0 || lat !== 1 || we_count !== w0) begin
            n_fail++;
            $display("FAIL fault_top_store: fault=%b data=%h lat=%0d writes=%0d want 1/0/1/0", f, d, lat, we_count - w0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hd;
        logic [4:0]  ht;
        int          n;
        bit          bad;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_tag = 5'd12;
        @(posedge clk); #1;
        // Queue the next request immediately; it must wait out the held response.
        bus.req_addr = 32'h3; bus.req_tag = 5'd13;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        hd = bus.resp_data; ht = bus.resp_tag;
        bad = (hd !== 32'hDEADBEEF) || (ht !== 5'd12);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== hd || bus.resp_tag !== ht ||
                bus.req_ready !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL backpressure_hold: data=%h tag=%0d valid=%b req_ready=%b want deadbeef/12/1/0",
                     bus.resp_data, bus.resp_tag, bus.resp_valid, bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (bus.resp_data !== 32'h11223344 || bus.resp_tag !== 5'd13 || n !== 3) begin
            n_fail++;
            $display("FAIL backpressure_next: data=%h tag=%0d lat=%0d want 11223344/13/3", bus.resp_data, bus.resp_tag, n);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        int w0;
        w0 = we_count;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEF00D; bus.req_tag = 5'd21;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_gates_we: mem_write_enable=%b want 0", mem_write_enable);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({bus.resp_valid, bus.resp_fault, bus.resp_data, bus.resp_tag, mem_address, mem_in, mem_size} !== '0 ||
            bus.req_ready !== 1'b1 || we_count !== w0) begin
            n_fail++;
            $display("FAIL rst_mid_access: valid=%b data=%h tag=%0d addr=%h in=%h size=%b writes=%0d want zeros",
                     bus.resp_valid, bus.resp_data, bus.resp_tag, mem_address, mem_in, mem_size, we_count - w0);
        end
        @(negedge clk);
        rst = 1'b0;
        model(0, 2'b10, 0, 32'h40, 32'h0, ed, ef, el);
        send(0, 2'b10, 0, 32'h40, 32'h0, 5'd22, d, f, t, lat);
        n_tests++;
        if (d !== ed) begin
            n_fail++;
            $display("FAIL rst_no_write: data=%h want %h", d, ed);
        end
    endtask

    task automatic test_random();
        bit          w, sg;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        logic [4:0]  tg;
        int          sel;
        for (int k = 0; k < 300; k++) begin
            w   = 1'($urandom);
            sg  = 1'($urandom);
            sz  = 2'($urandom);
            wd  = $urandom;
            tg  = 5'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = $urandom_range(0, 63);
            else if (sel < 9)  a = $urandom_range(0, MEM_BYTES - 1);
            else if (k % 2 == 0) a = 32'(MEM_BYTES - 4) + $urandom_range(0, 7);
            else               a = 32'hFFFFFFF0 + $urandom_range(0, 15);
            model(w, sz, sg, a, wd, ed, ef, el);
            send(w, sz, sg, a, wd, tg, d, f, t, lat);
            n_tests++;
            if (d !== ed || f !== ef || t !== tg || lat !== el) begin
                n_fail++;
                $display("FAIL random[%0d] w=%0d sz=%0d sg=%0d a=%h: data=%h fault=%b tag=%0d lat=%0d want %h/%b/%0d/%0d",
                         k, w, sz, sg, a, d, f, t, lat, ed, ef, tg, el);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
        preload = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) begin
            @(negedge clk);
            pl_addr    = 13'(i);
            pl_data    = 8'($urandom);
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        preload = 1'b0;
        test_reset();
        test_store_load();
        test_sign_extend();
        test_unaligned();
        test_fault();
        test_backpressure();
        test_reset_mid_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
